// File: rtl/pipelined_ks_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Latency is LAT = $clog2(WIDTH) + 2 cycles. One beat per cycle while out_ready=1.
// The whole pipeline advances or stalls together; a stalled result is held stable.
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  - input handshake (in_ready is combinational)
//   a, b, cin, sub      - operands, carry-in (add only), 0=add / 1=subtract
//   out_valid, out_ready- output handshake
//   sum, cout, ovf      - result, carry-out (no-borrow in sub), signed overflow
module pipelined_ks_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  // Stage k (0..LEVELS) registers: group generate/propagate, original p,
  // effective carry-in and the MSB of a (needed for the overflow rule).
  logic [WIDTH-1:0] g_q  [LEVELS+1];
  logic [WIDTH-1:0] p_q  [LEVELS+1];
  logic [WIDTH-1:0] pz_q [LEVELS+1];
  logic [LEVELS:0]  ci_q;
  logic [LEVELS:0]  am_q;
  logic [LEVELS:0]  vld;

  logic [WIDTH-1:0] g_n [LEVELS+1];
  logic [WIDTH-1:0] p_n [LEVELS+1];
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             advance;

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_n;
  logic             cout_n;
  logic             ovf_n;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Operand conditioning: subtract is a + ~b + 1, so cin is forced to 1.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin;

  // Bitwise g/p for stage 0, then one Kogge-Stone level per later stage.
  // Nodes below the span pass through unchanged (covers non power-of-two widths).
  always_comb begin
    g_n[0] = a & b_eff;
    p_n[0] = a ^ b_eff;
    for (int unsigned k = 1; k <= LEVELS; k++) begin
      int unsigned span;
      span   = 32'd1 << (k - 1);
      g_n[k] = g_q[k-1];
      p_n[k] = p_q[k-1];
      for (int unsigned i = span; i < WIDTH; i++) begin
        g_n[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-span]);
        p_n[k][i] = p_q[k-1][i] & p_q[k-1][i-span];
      end
    end
  end

  // Carry into bit i is the prefix (G,P) over bits i-1..0 applied to carry-in.
  always_comb begin
    carry  = {g_q[LEVELS][WIDTH-2:0] |
              (p_q[LEVELS][WIDTH-2:0] & {(WIDTH-1){ci_q[LEVELS]}}),
              ci_q[LEVELS]};
    sum_n  = pz_q[LEVELS] ^ carry;
    cout_n = g_q[LEVELS][WIDTH-1] | (p_q[LEVELS][WIDTH-1] & ci_q[LEVELS]);
    // Operand MSBs are equal exactly when the original p MSB is 0.
    ovf_n  = !pz_q[LEVELS][WIDTH-1] && (sum_n[WIDTH-1] != am_q[LEVELS]);
  end

  // Datapath registers: contents are don't-care while their stage is invalid.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int unsigned k = 0; k <= LEVELS; k++) begin
        g_q[k] <= g_n[k];
        p_q[k] <= p_n[k];
      end
      pz_q[0] <= p_n[0];
      for (int unsigned k = 1; k <= LEVELS; k++) begin
        pz_q[k] <= pz_q[k-1];
      end
      ci_q <= {ci_q[LEVELS-1:0], c_eff};
      am_q <= {am_q[LEVELS-1:0], a[WIDTH-1]};
    end
  end

  // Valid chain and output stage; bubbles shift through like beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      vld       <= {vld[LEVELS-1:0], in_valid};
      out_valid <= vld[LEVELS];
      sum       <= vld[LEVELS] ? sum_n : '0;
      cout      <= vld[LEVELS] & cout_n;
      ovf       <= vld[LEVELS] & ovf_n;
    end
  end

endmodule

// File: tb/tb_pipelined_ks_adder.sv
// Bench for pipelined_ks_adder: three instances (WIDTH 8, 5, 32) share one
// stimulus bus; each has a scoreboard fed by an arithmetic reference model.
module tb_pipelined_ks_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        cin;
  logic        sub;
  logic        out_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Reference: plain wide arithmetic, returns {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] ref_model(input int unsigned w, input logic [63:0] x,
                                            input logic [63:0] y, input logic ci,
                                            input logic sb);
    logic [64:0] mask, xa, yb, full;
    logic        co, ov;
    mask = (65'd1 << w) - 65'd1;
    xa   = {1'b0, x} & mask;
    yb   = (sb ? ~{1'b0, y} : {1'b0, y}) & mask;
    full = xa + yb + 65'(sb ? 1'b1 : ci);
    co   = full[w];
    ov   = (xa[w-1] == yb[w-1]) && (full[w-1] != xa[w-1]);
    return {ov, co, full[63:0] & mask[63:0]};
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar li = 0; li < 3; li++) begin : lane
    localparam int unsigned W = (li == 0) ? 8 : (li == 1) ? 5 : 32;
    logic          ir, ov, co, of;
    logic [W-1:0]  sw;
    logic [65:0]   q[$];
    logic [65:0]   held;
    logic [65:0]   cur;
    logic          hold_pend = 1'b0;
    int            qn = 0;

    pipelined_ks_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir),
      .a         (a_in[W-1:0]),
      .b         (b_in[W-1:0]),
      .cin       (cin),
      .sub       (sub),
      .out_valid (ov),
      .out_ready (out_ready),
      .sum       (sw),
      .cout      (co),
      .ovf       (of)
    );

    always @(negedge clk) begin
      cur = {of, co, 64'(sw)};
      if (!rst_n) begin
        q.delete();
        hold_pend = 1'b0;
        chk($sformatf("reset_state_w%0d", W), 66'({ir, ov, co, of, sw}),
            66'({1'b1, 3'b000, {W{1'b0}}}));
      end else begin
        chk($sformatf("in_ready_w%0d", W), 66'(ir), 66'(!ov || out_ready));
        if (hold_pend) begin
          chk($sformatf("stall_hold_w%0d", W), {ov, cur[64:0]}, {1'b1, held[64:0]});
          chk($sformatf("stall_hold_ovf_w%0d", W), cur, held);
        end
        hold_pend = 1'b0;
        if (ov) begin
          if (q.size() == 0) begin
            chk($sformatf("ghost_beat_w%0d", W), 66'(ov), 66'd0);
          end else if (out_ready) begin
            chk($sformatf("result_w%0d", W), cur, q.pop_front());
          end else begin
            held      = cur;
            hold_pend = 1'b1;
          end
        end else begin
          chk($sformatf("idle_zero_w%0d", W), cur, 66'd0);
        end
        if (in_valid && ir) q.push_back(ref_model(W, a_in, b_in, cin, sub));
      end
      qn = q.size();
    end
  end

  // One isolated beat on an empty pipeline; checks exact LAT=5 on the 8-bit lane.
  task automatic run_one(input logic [7:0] x, input logic [7:0] y, input logic ci,
                         input logic sb, input logic [7:0] es, input logic ec,
                         input logic eo);
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = 64'(x); b_in = 64'(y); cin = ci; sub = sb; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("latency_not_early", 66'(lane[0].ov), 66'd0);
    @(posedge clk);
    #1 chk("directed_result", {lane[0].ov, lane[0].of, lane[0].co, 64'(lane[0].sw)},
           {1'b1, eo, ec, 64'(es)});
  endtask

  function automatic logic [63:0] pick();
    case ($urandom % 8)
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0080_0000_0010;
      3: return 64'h7FFF_FF7F_FFFF_FFEF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic found;
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

    chk("model_add_ff_01", ref_model(8, 64'hFF, 64'h01, 1'b0, 1'b0), {1'b0, 1'b1, 64'h00});
    chk("model_sub_80_01", ref_model(8, 64'h80, 64'h01, 1'b0, 1'b1), {1'b1, 1'b1, 64'h7F});
    chk("model_sub_00_01", ref_model(8, 64'h00, 64'h01, 1'b1, 1'b1), {1'b0, 1'b0, 64'hFF});
    chk("model_w5_ovf",    ref_model(5, 64'h0F, 64'h01, 1'b0, 1'b0), {1'b1, 1'b0, 64'h10});
    chk("model_w32_cin",   ref_model(32, 64'hFFFF_FFFF, 64'h1, 1'b1, 1'b0), {1'b0, 1'b1, 64'h1});

    repeat (3) @(posedge clk);
    #1 chk("in_ready_during_reset", 66'(lane[0].ir), 66'd1);
    rst_n = 1'b1;
    #1 chk("in_ready_after_reset", 66'(lane[0].ir), 66'd1);

    run_one(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_one(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_one(8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

    // Stall: three back-to-back beats, hold out_ready low once the first is out.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a_in = 64'h1234_5678_9ABC_DE10 + 64'(i * 37);
      b_in = 64'h0F0F_0F0F_0F0F_0F20 + 64'(i * 91); cin = 1'b1; sub = (i == 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (lane[0].ov) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("stall_first_valid", 66'(found), 66'd1);
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready_low", 66'(lane[0].ir), 66'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("stall_drained_w8", 66'(lane[0].qn), 66'd0);

    // Reset mid-flight: beats in the pipe must be discarded.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_idle_w8", 66'(lane[0].ov), 66'd0);
    end

    // Random traffic with random backpressure.
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a_in      = pick();
      b_in      = pick();
      cin       = 1'($urandom);
      sub       = 1'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("final_drain_w8",  66'(lane[0].qn), 66'd0);
    chk("final_drain_w5",  66'(lane[1].qn), 66'd0);
    chk("final_drain_w32", 66'(lane[2].qn), 66'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
